// File: rtl/ws2812_rx.sv
// WS2812 serial stream decoder: classifies high pulses into bits, assembles 24-bit words MSB first, tags LED index.
// Latency: valid fires 1 clk after the synchronised fall of a word's 24th bit (3 clk after the pin fall).
// Backpressure: none; output strobes are single-cycle and the consumer must take them when they fire.
//
// Ports:
//   clk        12 MHz system clock
//   reset      asynchronous active-high reset
//   din        WS2812 serial line, asynchronous to clk
//   rgb_data   last decoded word, first received bit in bit 23 (held between strobes)
//   led_num    LED index of rgb_data (first word of a frame is NUM_LEDS-1)
//   valid      1-cycle strobe: rgb_data/led_num updated
//   frame_done 1-cycle strobe: reset gap seen after at least one bit
//   error      1-cycle strobe: protocol error detected
module ws2812_rx #(
    parameter int NUM_LEDS   = 8,
    parameter int T_ONE_MIN  = 8,
    parameter int T_HIGH_MIN = 2,
    parameter int T_HIGH_MAX = 20,
    parameter int T_RESET    = 600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        valid,
    output logic        frame_done,
    output logic        error
);

    localparam logic [9:0] RST_CNT  = 10'(T_RESET);
    localparam logic [4:0] ONE_MIN  = 5'(T_ONE_MIN);
    localparam logic [4:0] HIGH_MIN = 5'(T_HIGH_MIN);
    localparam logic [4:0] HIGH_MAX = 5'(T_HIGH_MAX);
    localparam logic [8:0] NLEDS    = 9'(NUM_LEDS);

    typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

    state_t      state, state_n;
    logic        sync1, din_s, din_q;
    logic        rise;
    logic [9:0]  low_cnt, low_cnt_n, low_inc;
    logic [4:0]  hi_cnt, hi_cnt_n, hi_inc;
    logic [4:0]  bit_cnt, bit_cnt_n;
    logic [8:0]  word_cnt, word_cnt_n;
    logic [23:0] shift, shift_n;
    logic        got_bit, got_bit_n;
    logic        gap;
    logic        bit_val;
    logic [23:0] rgb_n;
    logic [7:0]  led_n;
    logic        valid_n, frame_done_n, error_n;

    assign rise    = din_s & ~din_q;
    assign low_inc = (&low_cnt) ? low_cnt : low_cnt + 10'd1;
    assign hi_inc  = (&hi_cnt) ? hi_cnt : hi_cnt + 5'd1;
    // True only on the increment that lands on T_RESET; saturation keeps it from re-firing in one gap.
    assign gap     = (low_inc == RST_CNT) && (low_cnt != RST_CNT);

    always_comb begin
        state_n      = state;
        low_cnt_n    = low_cnt;
        hi_cnt_n     = hi_cnt;
        bit_cnt_n    = bit_cnt;
        word_cnt_n   = word_cnt;
        shift_n      = shift;
        got_bit_n    = got_bit;
        rgb_n        = rgb_data;
        led_n        = led_num;
        valid_n      = 1'b0;
        frame_done_n = 1'b0;
        error_n      = 1'b0;
        bit_val      = 1'b0;

        case (state)
            SYNC: begin
                if (din_s) begin
                    low_cnt_n = 10'd0;
                end else begin
                    low_cnt_n = low_inc;
                    // Silent re-alignment: no frame_done after an error or reset.
                    if (gap) begin
                        state_n    = LOW;
                        bit_cnt_n  = 5'd0;
                        word_cnt_n = 9'd0;
                        got_bit_n  = 1'b0;
                    end
                end
            end

            LOW: begin
                if (rise) begin
                    state_n   = HIGH;
                    hi_cnt_n  = 5'd1;
                    low_cnt_n = 10'd0;
                end else if (!din_s) begin
                    low_cnt_n = low_inc;
                    if (gap) begin
                        frame_done_n = got_bit;
                        error_n      = (bit_cnt != 5'd0);
                        bit_cnt_n    = 5'd0;
                        word_cnt_n   = 9'd0;
                        got_bit_n    = 1'b0;
                    end
                end
            end

            HIGH: begin
                if (din_s) begin
                    hi_cnt_n = hi_inc;
                    if (hi_inc > HIGH_MAX) begin
                        error_n   = 1'b1;
                        state_n   = SYNC;
                        low_cnt_n = 10'd0;
                    end
                end else if (hi_cnt < HIGH_MIN) begin
                    // Glitch; the fall cycle already counts as the first low cycle.
                    error_n   = 1'b1;
                    state_n   = SYNC;
                    low_cnt_n = 10'd1;
                end else begin
                    bit_val   = (hi_cnt >= ONE_MIN);
                    shift_n   = {shift[22:0], bit_val};
                    state_n   = LOW;
                    low_cnt_n = 10'd1;
                    got_bit_n = 1'b1;
                    if (bit_cnt == 5'd23) begin
                        bit_cnt_n = 5'd0;
                        if (word_cnt < NLEDS) begin
                            rgb_n      = shift_n;
                            led_n      = 8'(NLEDS - 9'd1 - word_cnt);
                            valid_n    = 1'b1;
                            word_cnt_n = word_cnt + 9'd1;
                        end else begin
                            error_n = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 5'd1;
                    end
                end
            end

            default: state_n = SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SYNC;
            sync1      <= 1'b0;
            din_s      <= 1'b0;
            din_q      <= 1'b0;
            low_cnt    <= 10'd0;
            hi_cnt     <= 5'd0;
            bit_cnt    <= 5'd0;
            word_cnt   <= 9'd0;
            shift      <= 24'd0;
            got_bit    <= 1'b0;
            rgb_data   <= 24'd0;
            led_num    <= 8'd0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            sync1      <= din;
            din_s      <= sync1;
            din_q      <= din_s;
            low_cnt    <= low_cnt_n;
            hi_cnt     <= hi_cnt_n;
            bit_cnt    <= bit_cnt_n;
            word_cnt   <= word_cnt_n;
            shift      <= shift_n;
            got_bit    <= got_bit_n;
            rgb_data   <= rgb_n;
            led_num    <= led_n;
            valid      <= valid_n;
            frame_done <= frame_done_n;
            error      <= error_n;
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Testbench for ws2812_rx: drives WS2812 waveforms, scoreboards decoded words, counts and times strobes.
// Latency: expected words carry the cycle they must appear (pin fall of 24th bit + 3).
// Backpressure: not applicable.
module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        valid, frame_done, error;

    ws2812_rx dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .rgb_data   (rgb_data),
        .led_num    (led_num),
        .valid      (valid),
        .frame_done (frame_done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [23:0] d;
        logic [7:0]  l;
        int          due;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          vld_cnt = 0, fd_cnt = 0, err_cnt = 0;
    int          fd_cyc = 0, err_cyc = 0;
    logic        pv = 1'b0, pf = 1'b0, pe = 1'b0;
    int          last_fall = 0;
    logic [23:0] last_d = 24'd0;
    logic [7:0]  last_l = 8'd0;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (valid) begin
            vld_cnt++;
            chk("valid_width", 32'(pv), 32'd0);
            if (q.size() == 0) begin
                chk("spurious_valid", 32'(valid), 32'd0);
            end else begin
                cur = q.pop_front();
                chk("rgb_data", 32'(rgb_data), 32'(cur.d));
                chk("led_num", 32'(led_num), 32'(cur.l));
                chk("valid_time", cyc, cur.due);
            end
        end
        if (frame_done) begin
            chk("fd_width", 32'(pf), 32'd0);
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (error) begin
            chk("err_width", 32'(pe), 32'd0);
            err_cnt++;
            err_cyc = cyc;
        end
        pv = valid;
        pf = frame_done;
        pe = error;
    end

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(posedge clk);
            #1 din = v;
        end
    endtask

    task automatic send_bit(input logic b, input logic push, input logic [23:0] w, input logic [7:0] led);
        exp_t e;
        drive(1'b1, b ? 10 : 5);
        @(posedge clk);
        #1 din = 1'b0;
        last_fall = cyc;
        if (push) begin
            e.d   = w;
            e.l   = led;
            e.due = cyc + 3;
            q.push_back(e);
            last_d = w;
            last_l = led;
        end
        drive(1'b0, b ? 5 : 10);
    endtask

    // Sends the top nbits of w, MSB first; push only applies to a complete word.
    task automatic send_bits(input logic [23:0] w, input int nbits, input logic push, input logic [7:0] led);
        for (int i = 23; i >= 24 - nbits; i--)
            send_bit(w[i], push && (i == 0), w, led);
    endtask

    int f0, e0, v0, lf, r;

    initial begin
        reset = 1'b1;
        din   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", 32'(rgb_data), 32'd0);
        chk("rst_led", 32'(led_num), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single word after a preamble gap.
        f0 = fd_cnt; e0 = err_cnt; v0 = vld_cnt;
        drive(1'b0, 800);
        send_bits(24'hA5C3F0, 24, 1'b1, 8'd7);
        lf = last_fall;
        drive(1'b0, 800);
        chk("t1_valid_cnt", vld_cnt - v0, 1);
        chk("t1_fd_cnt", fd_cnt - f0, 1);
        chk("t1_fd_time", fd_cyc, lf + 602);
        chk("t1_err_cnt", err_cnt - e0, 0);

        // Full frame of 8 words.
        f0 = fd_cnt; e0 = err_cnt; v0 = vld_cnt;
        for (int i = 0; i < 8; i++)
            send_bits(24'(i + 1), 24, 1'b1, 8'(7 - i));
        drive(1'b0, 800);
        chk("t2_valid_cnt", vld_cnt - v0, 8);
        chk("t2_fd_cnt", fd_cnt - f0, 1);
        chk("t2_err_cnt", err_cnt - e0, 0);
        chk("t2_drain", q.size(), 0);

        // 1-cycle glitch mid-word; rest of frame is ignored.
        f0 = fd_cnt; e0 = err_cnt; v0 = vld_cnt;
        send_bits(24'hABCDEF, 12, 1'b0, 8'd0);
        drive(1'b1, 1);
        drive(1'b0, 10);
        send_bits(24'h123ABC, 24, 1'b0, 8'd0);
        drive(1'b0, 800);
        chk("t3_err_cnt", err_cnt - e0, 1);
        chk("t3_valid_cnt", vld_cnt - v0, 0);
        chk("t3_fd_cnt", fd_cnt - f0, 0);
        f0 = fd_cnt; v0 = vld_cnt;
        send_bits(24'h123456, 24, 1'b1, 8'd7);
        drive(1'b0, 800);
        chk("t3_clean_valid", vld_cnt - v0, 1);
        chk("t3_clean_fd", fd_cnt - f0, 1);

        // 25-cycle high pulse.
        f0 = fd_cnt; e0 = err_cnt; v0 = vld_cnt;
        @(posedge clk);
        #1 din = 1'b1;
        r = cyc;
        drive(1'b1, 24);
        drive(1'b0, 800);
        chk("t4_err_cnt", err_cnt - e0, 1);
        chk("t4_err_time", err_cyc, r + 23);
        send_bits(24'h00FF00, 24, 1'b1, 8'd7);
        send_bits(24'hFF0000, 24, 1'b1, 8'd6);
        drive(1'b0, 800);
        chk("t4_valid_cnt", vld_cnt - v0, 2);
        chk("t4_fd_cnt", fd_cnt - f0, 1);
        chk("t4_err_total", err_cnt - e0, 1);

        // Partial word then gap.
        f0 = fd_cnt; e0 = err_cnt; v0 = vld_cnt;
        send_bits(24'h3C3C3C, 12, 1'b0, 8'd0);
        lf = last_fall;
        drive(1'b0, 800);
        chk("t5_fd_cnt", fd_cnt - f0, 1);
        chk("t5_err_cnt", err_cnt - e0, 1);
        chk("t5_fd_time", fd_cyc, lf + 602);
        chk("t5_err_time", err_cyc, lf + 602);
        chk("t5_valid_cnt", vld_cnt - v0, 0);
        chk("t5_rgb_hold", 32'(rgb_data), 32'(last_d));
        chk("t5_led_hold", 32'(led_num), 32'(last_l));

        // Nine words in one frame.
        f0 = fd_cnt; e0 = err_cnt; v0 = vld_cnt;
        for (int i = 0; i < 9; i++)
            send_bits(24'h000100 + 24'(i), 24, i < 8, 8'(7 - i));
        lf = last_fall;
        drive(1'b0, 800);
        chk("t5x_err_cnt", err_cnt - e0, 1);
        chk("t5x_err_time", err_cyc, lf + 3);
        chk("t5x_valid_cnt", vld_cnt - v0, 8);
        chk("t5x_fd_cnt", fd_cnt - f0, 1);
        chk("t5x_led", 32'(led_num), 32'd0);
        chk("t5x_rgb", 32'(rgb_data), 32'h000107);

        // Reset during bit 10.
        f0 = fd_cnt; e0 = err_cnt; v0 = vld_cnt;
        send_bits(24'hFFFFFF, 9, 1'b0, 8'd0);
        drive(1'b1, 3);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t6_rgb", 32'(rgb_data), 32'd0);
        chk("t6_led", 32'(led_num), 32'd0);
        chk("t6_valid", 32'(valid), 32'd0);
        chk("t6_fd", 32'(frame_done), 32'd0);
        chk("t6_err", 32'(error), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        drive(1'b1, 6);
        drive(1'b0, 6);
        send_bits(24'h55AA55, 24, 1'b0, 8'd0);
        drive(1'b0, 800);
        chk("t6_ignored_valid", vld_cnt - v0, 0);
        send_bits(24'h0F1E2D, 24, 1'b1, 8'd7);
        drive(1'b0, 800);
        chk("t6_valid_cnt", vld_cnt - v0, 1);
        chk("t6_fd_cnt", fd_cnt - f0, 1);
        chk("t6_err_cnt", err_cnt - e0, 0);

        for (int i = 0; i < 100 && q.size() != 0; i++)
            @(posedge clk);
        chk("final_drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
